// File: rtl/tinymem_arbiter_if.sv
// tinymem_arbiter_if: CPU requester, DMA requester and memory-side signals of
// tinymem_arbiter. The master modport is the requester/memory side, the slave
// modport is the arbiter itself.
interface tinymem_arbiter_if #(
   parameter int unsigned AW = 8,
   parameter int unsigned DW = 8
);

   // CPU port
   logic          cpu_req;
   logic          cpu_we;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_wdata;
   logic          cpu_gnt;
   logic          cpu_rvalid;
   logic [DW-1:0] cpu_rdata;

   // DMA / loader port
   logic          dma_req;
   logic          dma_we;
   logic [AW-1:0] dma_addr;
   logic [DW-1:0] dma_wdata;
   logic          dma_lock;
   logic          dma_gnt;
   logic          dma_rvalid;
   logic [DW-1:0] dma_rdata;

   // Shared synchronous memory port
   logic          mem_en;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  cpu_gnt, cpu_rvalid, cpu_rdata,
      output dma_req, dma_we, dma_addr, dma_wdata, dma_lock,
      input  dma_gnt, dma_rvalid, dma_rdata,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      output mem_rdata
   );

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output cpu_gnt, cpu_rvalid, cpu_rdata,
      input  dma_req, dma_we, dma_addr, dma_wdata, dma_lock,
      output dma_gnt, dma_rvalid, dma_rdata,
      output mem_en, mem_we, mem_addr, mem_wdata,
      input  mem_rdata
   );

endinterface

// File: rtl/tinymem_arbiter.sv
// tinymem_arbiter: shares one synchronous memory between the CPU and a
// DMA/loader requester. At most one grant per cycle, CPU priority by default,
// DMA may lock the memory for bursts. Read data is returned to the winner one
// cycle after its grant.
// Optional feature: define TINYARB_STARVE_GUARD_EN to let DMA win once after
// STARVE_LIMIT consecutive CPU grants taken while DMA was waiting.
module tinymem_arbiter #(
   parameter int unsigned AW           = 8,
   parameter int unsigned DW           = 8,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic                clk,
   input  logic                reset,
   tinymem_arbiter_if.slave    bus
);

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_CPU  = 2'd1,
      OWN_DMA  = 2'd2
   } owner_e;

   owner_e        rd_owner_q;
   owner_e        rd_owner_d;
   logic          locked_q;
   logic          locked_d;

   logic          lock_active_c;
   logic          starve_force_c;
   logic          cpu_win_c;
   logic          dma_win_c;
   logic          sel_we_c;
   logic [AW-1:0] sel_addr_c;
   logic [DW-1:0] sel_wdata_c;

   // A zero limit would make the guard counter zero bits wide.
   if (STARVE_LIMIT == 0) begin : g_bad_limit
      $error("tinymem_arbiter: STARVE_LIMIT must be at least 1");
   end

   // The lock only holds while the DMA keeps dma_lock high; dropping it frees
   // the CPU in that very cycle.
   assign lock_active_c = locked_q & bus.dma_lock;

`ifdef TINYARB_STARVE_GUARD_EN
   localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);

   logic [CW-1:0] starve_cnt_q;
   logic [CW-1:0] starve_cnt_d;

   // DMA is forced through once the CPU has won STARVE_LIMIT times in a row.
   assign starve_force_c = bus.dma_req & (starve_cnt_q == CW'(STARVE_LIMIT));

   // Count CPU wins taken while DMA waits; any DMA grant or idle DMA clears.
   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (!bus.dma_req || dma_win_c) begin
         starve_cnt_d = '0;
      end else if (cpu_win_c && !lock_active_c) begin
         starve_cnt_d = starve_cnt_q + CW'(1);
      end
   end

   // Starvation counter register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         starve_cnt_q <= '0;
      end else begin
         starve_cnt_q <= starve_cnt_d;
      end
   end
`else
   assign starve_force_c = 1'b0;
`endif

   // Grant selection: locked DMA, then starvation guard, then CPU, then DMA.
   always_comb begin
      cpu_win_c = 1'b0;
      dma_win_c = 1'b0;
      if (reset) begin
         if (lock_active_c) begin
            dma_win_c = bus.dma_req;
         end else if (starve_force_c) begin
            dma_win_c = 1'b1;
         end else if (bus.cpu_req) begin
            cpu_win_c = 1'b1;
         end else begin
            dma_win_c = bus.dma_req;
         end
      end
   end

   // Memory port mux; address/data idle on the CPU values.
   always_comb begin
      sel_we_c    = 1'b0;
      sel_addr_c  = bus.cpu_addr;
      sel_wdata_c = bus.cpu_wdata;
      if (dma_win_c) begin
         sel_we_c    = bus.dma_we;
         sel_addr_c  = bus.dma_addr;
         sel_wdata_c = bus.dma_wdata;
      end else if (cpu_win_c) begin
         sel_we_c    = bus.cpu_we;
      end
   end

   assign bus.cpu_gnt   = cpu_win_c;
   assign bus.dma_gnt   = dma_win_c;
   assign bus.mem_en    = cpu_win_c | dma_win_c;
   assign bus.mem_we    = sel_we_c;
   assign bus.mem_addr  = sel_addr_c;
   assign bus.mem_wdata = sel_wdata_c;

   // Next read owner and lock state.
   always_comb begin
      rd_owner_d = OWN_NONE;
      locked_d   = locked_q;
      if (cpu_win_c && !bus.cpu_we) begin
         rd_owner_d = OWN_CPU;
      end else if (dma_win_c && !bus.dma_we) begin
         rd_owner_d = OWN_DMA;
      end
      if (!bus.dma_lock) begin
         locked_d = 1'b0;
      end else if (dma_win_c) begin
         locked_d = 1'b1;
      end
   end

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_owner_q <= OWN_NONE;
         locked_q   <= 1'b0;
      end else begin
         rd_owner_q <= rd_owner_d;
         locked_q   <= locked_d;
      end
   end

   // Read data comes straight from memory; only the owner sees rvalid.
   assign bus.cpu_rvalid = (rd_owner_q == OWN_CPU);
   assign bus.dma_rvalid = (rd_owner_q == OWN_DMA);
   assign bus.cpu_rdata  = bus.mem_rdata;
   assign bus.dma_rdata  = bus.mem_rdata;

   // Structural properties of the grant logic.
   a_one_gnt: assert property (@(posedge clk) disable iff (!reset)
      !(bus.cpu_gnt && bus.dma_gnt));
   a_lock_excl: assert property (@(posedge clk) disable iff (!reset)
      lock_active_c |-> !bus.cpu_gnt);
   a_en_gnt: assert property (@(posedge clk) disable iff (!reset)
      bus.mem_en == (bus.cpu_gnt || bus.dma_gnt));

endmodule
